i2s_codec_if: RTL and testbench

Master-mode I2S interface between the audio codec and the pedalboard core. It generates the bit clock and word select, deserialises the ADC left channel into the core's input sample, and emits a one-cycle sample tick per frame. It serialises the core's output sample to both DAC channels. It sits on both sides of the effect chain: its `data_o`/`sample_tick_o` feed the chain input, and the chain output returns on `data_i`.

---
 rtl/main_config.sv | 19 +
 rtl/i2s_clk_gen.sv | 51 +++++
 rtl/i2s_codec_if.sv | 95 +++++++++
 tb/tb_i2s_codec_if.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/main_config.sv
// Pedalboard build configuration shared by the top level and the testbench.
// Holds the codec link geometry and the word-select encoding.
package main_config;

  localparam int CODEC_DATA_WIDTH = 16;
  localparam int CODEC_SLOT_WIDTH = 32;
  localparam int CODEC_CLK_DIV    = 8;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // clk_i cycles per stereo frame (one sample_tick_o period).
  function automatic int codec_frame_cycles(input int clk_div, input int slot_width);
    return 4 * clk_div * slot_width;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master clocking: BCLK divider, frame bit counter and word select.
// rise_stb/fall_stb are high on the clk_i edge where bclk_o toggles.
module i2s_clk_gen
  import main_config::*;
#(
  parameter int SLOT_WIDTH = CODEC_SLOT_WIDTH,
  parameter int CLK_DIV    = CODEC_CLK_DIV,
  parameter int BIT_CNT_W  = $clog2(2 * SLOT_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  output logic                 bclk_o,
  output logic                 lrclk_o,
  output logic                 rise_stb,
  output logic                 fall_stb,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] SLOT_B   = BIT_CNT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]     div_cnt;
  logic                 div_last;
  logic [BIT_CNT_W-1:0] bit_nxt;

  assign div_last = (div_cnt == DIV_LAST);
  assign rise_stb = div_last & ~bclk_o;
  assign fall_stb = div_last & bclk_o;
  assign bit_nxt  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (srst_i) begin
      div_cnt <= '0;
      bclk_o  <= 1'b0;
      lrclk_o <= SLOT_LEFT;
      bit_cnt <= '0;
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      if (div_last) bclk_o <= ~bclk_o;
      // Word select changes with the falling BCLK, one bit ahead of the MSB.
      if (fall_stb) begin
        bit_cnt <= bit_nxt;
        lrclk_o <= (bit_nxt >= SLOT_B) ? SLOT_RIGHT : SLOT_LEFT;
      end
    end
  end

endmodule

// File: rtl/i2s_codec_if.sv
// Master-mode I2S link to the codec: captures the ADC left channel into data_o
// with a per-frame tick, and plays one latched sample on both DAC channels.
module i2s_codec_if
  import main_config::*;
#(
  parameter int DATA_WIDTH = CODEC_DATA_WIDTH,
  parameter int SLOT_WIDTH = CODEC_SLOT_WIDTH,
  parameter int CLK_DIV    = CODEC_CLK_DIV
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  input  logic                  adc_data_i,
  output logic                  dac_data_o,
  input  logic                  din_dout_shortcut_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sample_tick_o
);

  localparam int BCW   = $clog2(2 * SLOT_WIDTH);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] DW_B     = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0] SLOT_B   = BCW'(SLOT_WIDTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(2 * SLOT_WIDTH - 1);

  if (SLOT_WIDTH < DATA_WIDTH + 1) begin : g_bad_slot
    $error("i2s_codec_if: SLOT_WIDTH must be at least DATA_WIDTH+1");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("i2s_codec_if: CLK_DIV must be at least 2");
  end

  logic           rise_stb;
  logic           fall_stb;
  logic [BCW-1:0] bit_cnt;

  i2s_clk_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .CLK_DIV    (CLK_DIV),
    .BIT_CNT_W  (BCW)
  ) u_clk_gen (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .bclk_o   (bclk_o),
    .lrclk_o  (lrclk_o),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .bit_cnt  (bit_cnt)
  );

  // The last received bit goes straight into data_o, so the shifter is one bit short.
  logic [DATA_WIDTH-2:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx;
  logic [BCW-1:0]        bit_nxt;
  logic [BCW-1:0]        pos_nxt;
  logic [IDX_W-1:0]      tx_idx;
  logic                  dac_nxt;

  always_comb begin
    // NOTE: every variable gets a default first, so no path infers a latch.
    bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    pos_nxt = (bit_nxt >= SLOT_B) ? bit_nxt - SLOT_B : bit_nxt;
    tx_idx  = IDX_W'(DW_B - pos_nxt);
    dac_nxt = 1'b0;
    if (pos_nxt != '0 && pos_nxt <= DW_B) dac_nxt = tx[tx_idx];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rx_sr         <= '0;
      data_o        <= '0;
      sample_tick_o <= 1'b0;
      tx            <= '0;
      dac_data_o    <= 1'b0;
    end else begin
      sample_tick_o <= 1'b0;
      // Left slot only: bit_cnt 1..DATA_WIDTH is below SLOT_WIDTH by construction.
      if (rise_stb && bit_cnt != '0 && bit_cnt <= DW_B) begin
        rx_sr <= {rx_sr[DATA_WIDTH-3:0], adc_data_i};
        if (bit_cnt == DW_B) begin
          data_o        <= {rx_sr, adc_data_i};
          sample_tick_o <= 1'b1;
        end
      end
      if (fall_stb) begin
        dac_data_o <= dac_nxt;
        // Source choice is sampled only at the frame wrap, so a shortcut change never splits a frame.
        if (bit_nxt == '0) tx <= din_dout_shortcut_i ? data_o : data_i;
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_if.sv
// Self-checking bench for i2s_codec_if: a frame-arithmetic model of the I2S link
// plays the codec and predicts every output cycle by cycle.
module tb_i2s_codec_if;
  import main_config::*;

  localparam int DW     = CODEC_DATA_WIDTH;
  localparam int V_DIV  = 2;
  localparam int V_SLOT = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst0 = 1'b1, srst1 = 1'b1;
  logic          adc = 1'b0, sc = 1'b0;
  logic [DW-1:0] din = '0;

  logic          bclk0, lr0, dac0, tick0;
  logic          bclk1, lr1, dac1, tick1;
  logic [DW-1:0] dout0, dout1;

  i2s_codec_if #(
    .DATA_WIDTH (DW),
    .SLOT_WIDTH (CODEC_SLOT_WIDTH),
    .CLK_DIV    (CODEC_CLK_DIV)
  ) u_dut0 (
    .clk_i               (clk),
    .srst_i              (srst0),
    .bclk_o              (bclk0),
    .lrclk_o             (lr0),
    .adc_data_i          (adc),
    .dac_data_o          (dac0),
    .din_dout_shortcut_i (sc),
    .data_i              (din),
    .data_o              (dout0),
    .sample_tick_o       (tick0)
  );

  i2s_codec_if #(
    .DATA_WIDTH (DW),
    .SLOT_WIDTH (V_SLOT),
    .CLK_DIV    (V_DIV)
  ) u_dut1 (
    .clk_i               (clk),
    .srst_i              (srst1),
    .bclk_o              (bclk1),
    .lrclk_o             (lr1),
    .adc_data_i          (adc),
    .dac_data_o          (dac1),
    .din_dout_shortcut_i (sc),
    .data_i              (din),
    .data_o              (dout1),
    .sample_tick_o       (tick1)
  );

  bit            sel = 1'b0;
  logic          bclk_a, lr_a, dac_a, tick_a;
  logic [DW-1:0] dout_a;
  assign bclk_a = sel ? bclk1 : bclk0;
  assign lr_a   = sel ? lr1   : lr0;
  assign dac_a  = sel ? dac1  : dac0;
  assign tick_a = sel ? tick1 : tick0;
  assign dout_a = sel ? dout1 : dout0;

  int checks = 0, failures = 0;
  int clk_div, slot_w, frame, t, last_tick;
  bit rand_words, seen_rise;
  logic [DW-1:0] tx_m, exp_data, cur_left, cur_right, fix_left, fix_right;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic pick_words();
    if (rand_words) begin
      cur_left  = DW'($urandom);
      cur_right = DW'($urandom);
    end else begin
      cur_left  = fix_left;
      cur_right = fix_right;
    end
  endtask

  // Codec side: new bit after each BCLK fall, one BCLK after the word-select change.
  task automatic drive_adc();
    int b, p;
    logic [DW-1:0] w;
    b = (t / (2 * clk_div)) % (2 * slot_w);
    p = b % slot_w;
    w = (b >= slot_w) ? cur_right : cur_left;
    if (p >= 1 && p <= DW) adc = w[DW-p];
    else adc = 1'($urandom);
  endtask

  task automatic step();
    int ft, b, p;
    logic e_dac;
    @(posedge clk);
    #1;
    t++;
    ft = t % frame;
    b  = (t / (2 * clk_div)) % (2 * slot_w);
    p  = b % slot_w;
    if (ft == 0) begin
      tx_m = sc ? exp_data : din;
      pick_words();
    end
    if (ft == 2 * clk_div * DW + clk_div) exp_data = cur_left;
    e_dac = (p >= 1 && p <= DW) ? tx_m[DW-p] : 1'b0;
    check("bclk", bclk_a, (t / clk_div) % 2);
    check("lrclk", lr_a, b >= slot_w);
    check("dac", dac_a, e_dac);
    check("tick", tick_a, ft == 2 * clk_div * DW + clk_div);
    check("data_o", dout_a, exp_data);
    if (tick_a) begin
      if (last_tick >= 0) check("tick_gap", t - last_tick, frame);
      last_tick = t;
    end
    if (!seen_rise && bclk_a) begin
      check("first_rise", t, clk_div);
      seen_rise = 1'b1;
    end
    drive_adc();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_for(input int n);
    if (sel) srst1 = 1'b1;
    else srst0 = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_bclk", bclk_a, 0);
      check("rst_lrclk", lr_a, 0);
      check("rst_dac", dac_a, 0);
      check("rst_tick", tick_a, 0);
      check("rst_data_o", dout_a, 0);
    end
    if (sel) srst1 = 1'b0;
    else srst0 = 1'b0;
    t = 0;
    tx_m = '0;
    exp_data = '0;
    last_tick = -1;
    seen_rise = 1'b0;
    pick_words();
    drive_adc();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0;
    clk_div = CODEC_CLK_DIV;
    slot_w  = CODEC_SLOT_WIDTH;
    frame   = codec_frame_cycles(clk_div, slot_w);
    t = 0;

    // Fixed ADC pattern, held chain output.
    rand_words = 1'b0;
    fix_left   = 16'h8001;
    fix_right  = 16'h7FFF;
    din        = 16'hA5C3;
    sc         = 1'b0;
    reset_for(4);
    run(3 * frame + 100);

    // Shortcut loop-back, then a mid-frame toggle that must wait for the wrap.
    fix_left = 16'h1234;
    din      = '0;
    sc       = 1'b1;
    run(2 * frame);
    while (t % frame != frame / 2) step();
    sc = 1'b0;
    run(frame);
    sc = 1'b1;
    run(2 * frame);

    // Random words, random chain data and shortcut changes at arbitrary cycles.
    rand_words = 1'b1;
    repeat (8 * frame) begin
      step();
      if ($urandom_range(0, 199) == 0) din = DW'($urandom);
      if ($urandom_range(0, 599) == 0) sc = ~sc;
    end

    // Reset in the middle of the left slot.
    while (t % frame != 2 * clk_div * 20 + 5) step();
    reset_for(3);
    run(2 * frame + 50);

    // Narrow-slot, fast-BCLK instance.
    srst0   = 1'b1;
    sel     = 1'b1;
    clk_div = V_DIV;
    slot_w  = V_SLOT;
    frame   = codec_frame_cycles(clk_div, slot_w);
    sc      = 1'b1;
    reset_for(3);
    run(4 * frame);
    repeat (8 * frame) begin
      step();
      if ($urandom_range(0, 49) == 0) din = DW'($urandom);
      if ($urandom_range(0, 149) == 0) sc = ~sc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
